mdu_iterative: RTL

//  Iterative multiply/divide unit for the MIPS32 core's HI/LO path.

---
 rtl/mdu_iterative.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iterative.sv
// mdu_iterative
//   Iterative radix-2 multiply/divide unit with architectural HI/LO registers
//   for the MIPS32 core. One result bit is produced per clock. The sequence is
//   IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     launch an operation (sampled only in IDLE)
//   op        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_val    operand A (multiplicand / dividend)
//   rt_val    operand B (multiplier / divisor)
//   flush     abort the in-flight operation, no result is written
//   hi_we     MTHI strobe (IDLE only)
//   lo_we     MTLO strobe (IDLE only)
//   wdata     MTHI/MTLO data
//   busy      operation in flight
//   done      one-cycle pulse, HI/LO hold the new result
//   div_zero  one-cycle pulse with done when a divide had a zero divisor
//   hi, lo    architectural HI/LO registers
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_ITER = 2'b10,
    S_FIX  = 2'b11
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;        // raw operand A captured at start
  logic [WIDTH-1:0]   b_q;        // raw operand B captured at start
  logic [WIDTH-1:0]   m_q;        // |A| for multiply (addend), |B| for divide (divisor)
  logic [2*WIDTH-1:0] acc_q;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_lo_q;   // negate product / quotient in FIX
  logic               neg_hi_q;   // negate remainder in FIX
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;

  logic               is_div_s;
  logic               is_signed_s;
  logic               sign_a_s;
  logic               sign_b_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;
  logic               fix_dz_s;

  assign is_div_s    = op_q[1];
  assign is_signed_s = op_q[0];
  assign sign_a_s    = is_signed_s & a_q[WIDTH-1];
  assign sign_b_s    = is_signed_s & b_q[WIDTH-1];

  // Operand magnitudes used to seed the iteration (raw for unsigned ops).
  always_comb begin
    mag_a_s = sign_a_s ? (~a_q + {{(WIDTH-1){1'b0}}, 1'b1}) : a_q;
    mag_b_s = sign_b_s ? (~b_q + {{(WIDTH-1){1'b0}}, 1'b1}) : b_q;
  end

  // One iteration step of shift-add multiply and restoring divide.
  always_comb begin
    // Multiply: add addend into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right, carry included.
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    // Divide: shift next dividend bit into the remainder, trial-subtract the
    // divisor; bit WIDTH of the difference is the borrow.
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, m_q};
    if (!div_diff_s[WIDTH]) begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up and divide-by-zero override for the final HI/LO values.
  always_comb begin
    prod_s   = neg_lo_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    fix_dz_s = 1'b0;
    if (is_div_s) begin
      if (b_q == {WIDTH{1'b0}}) begin
        fix_lo_s = {WIDTH{1'b1}};
        fix_hi_s = a_q;
        fix_dz_s = 1'b1;
      end else begin
        fix_lo_s = neg_lo_q ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                            : acc_q[WIDTH-1:0];
        fix_hi_s = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                            : acc_q[2*WIDTH-1:WIDTH];
      end
    end else begin
      fix_lo_s = prod_s[WIDTH-1:0];
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, datapath registers and HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      m_q        <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q    <= op;
            a_q     <= rs_val;
            b_q     <= rt_val;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            m_q      <= is_div_s ? mag_b_s : mag_a_s;
            acc_q    <= {{WIDTH{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
            neg_lo_q <= sign_a_s ^ sign_b_s;
            neg_hi_q <= is_div_s ? sign_a_s : (sign_a_s ^ sign_b_s);
            cnt_q    <= {CNT_W{1'b0}};
            state_q  <= S_ITER;
          end
        end
        S_ITER: begin
          if (flush) begin
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= is_div_s ? div_next_s : mul_next_s;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= {CNT_W{1'b0}};
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!flush) begin
            hi_q       <= fix_hi_s;
            lo_q       <= fix_lo_s;
            done_q     <= 1'b1;
            div_zero_q <= fix_dz_s;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
